// File: rtl/gpc_ifu.sv
`default_nettype none
// ============================================================================
// gpc_ifu : Gwen core instruction fetch unit (PC, imem requests, word buffer)
// Option  : GPC_IFU_MISALIGN_TRAP_EN traps misaligned redirects into HALT
// Rev 1.0
// ============================================================================
module gpc_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        halted,
    output logic        fetch_fault
);
    localparam int              c_AW        = $clog2(DEPTH);
    localparam int              c_CW        = c_AW + 1;
    localparam logic [c_CW:0]   c_DEPTH_EXT = (c_CW + 1)'(DEPTH);
    localparam logic [c_AW-1:0] c_PTR_ONE   = 1;
    localparam logic [c_CW-1:0] c_CNT_ONE   = 1;
    localparam logic [0:0]      c_RUN       = 1'b0;
    localparam logic [0:0]      c_HALT      = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [31:0]     pc_q, pc_d, req_addr_q, req_addr_d, rsp_pc_q, rsp_pc_d;
    logic            req_valid_q, req_valid_d;
    logic [c_CW-1:0] cnt_q, cnt_d, infl_q, infl_d, drop_q, drop_d;
    logic [c_AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [31:0]     buf_data_q [DEPTH];
    logic [31:0]     buf_pc_q   [DEPTH];

    logic            w_misalign, w_trap, w_redir, w_flush;
    logic            w_accept, w_push, w_pop, w_issue;
    logic [31:0]     w_target, w_pc_base;
    logic [c_CW:0]   w_used;

`ifdef GPC_IFU_MISALIGN_TRAP_EN
    assign w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // halt outranks redirect; a trapped redirect is treated exactly like a halt
    assign w_trap    = (state_q == c_RUN) && (halt || w_misalign);
    assign w_redir   = (state_q == c_RUN) && !halt && redirect_valid && !w_misalign;
    assign w_flush   = w_trap || w_redir || (state_q == c_HALT);
    assign w_target  = redirect_pc & 32'hFFFF_FFFC;
    assign w_pc_base = w_redir ? w_target : pc_q;

    assign w_accept  = req_valid_q && imem_req_ready;
    assign w_push    = imem_rsp_valid && (drop_q == '0) && !w_flush;
    assign w_pop     = inst_valid && inst_ready && !w_flush;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= c_RUN;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (w_trap) state_d = c_HALT;
    end

    // FSM: outputs
    always_comb begin
        halted = (state_q == c_HALT);
    end

    // Credit looks at occupancy after this cycle's pushes, pops, accepts and returns
    assign w_used  = {1'b0, cnt_d} + {1'b0, infl_d};
    assign w_issue = (state_d == c_RUN) && (!req_valid_q || imem_req_ready) && (w_used < c_DEPTH_EXT);

    always_comb begin
        infl_d = infl_q + c_CW'(w_accept) - c_CW'(imem_rsp_valid);

        cnt_d = cnt_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        if (w_flush) begin
            cnt_d = '0;
            rd_d  = '0;
            wr_d  = '0;
        end else begin
            cnt_d = cnt_q + c_CW'(w_push) - c_CW'(w_pop);
            if (w_push) wr_d = wr_q + c_PTR_ONE;
            if (w_pop)  rd_d = rd_q + c_PTR_ONE;
        end

        // Everything already accepted or still waiting for accept belongs to the old stream
        drop_d = drop_q;
        if (w_trap || w_redir)
            drop_d = infl_d + c_CW'(req_valid_q && !imem_req_ready);
        else if (imem_rsp_valid && (drop_q != '0))
            drop_d = drop_q - c_CNT_ONE;

        req_valid_d = req_valid_q && !imem_req_ready;
        req_addr_d  = req_addr_q;
        pc_d        = w_pc_base;
        if (w_issue) begin
            req_valid_d = 1'b1;
            req_addr_d  = w_pc_base;
            pc_d        = w_pc_base + 32'd4;
        end

        rsp_pc_d = rsp_pc_q;
        if (w_redir)     rsp_pc_d = w_target;
        else if (w_push) rsp_pc_d = rsp_pc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            req_valid_q <= 1'b0;
            cnt_q       <= '0;
            infl_q      <= '0;
            drop_q      <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
        end else begin
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            rsp_pc_q    <= rsp_pc_d;
            req_valid_q <= req_valid_d;
            cnt_q       <= cnt_d;
            infl_q      <= infl_d;
            drop_q      <= drop_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            buf_data_q[wr_q] <= imem_rsp_data;
            buf_pc_q[wr_q]   <= rsp_pc_q;
        end
    end

`ifdef GPC_IFU_MISALIGN_TRAP_EN
    logic fault_q;
    always_ff @(posedge clk) begin
        if (rst)                                   fault_q <= 1'b0;
        else if ((state_q == c_RUN) && !halt && w_misalign) fault_q <= 1'b1;
    end
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign inst_valid     = (cnt_q != '0);
    assign inst           = inst_valid ? buf_data_q[rd_q] : '0;
    assign inst_pc        = inst_valid ? buf_pc_q[rd_q]   : '0;

endmodule
`default_nettype wire
